// File: rtl/bldc_commutator_if.sv
// Command/status bundle for bldc_commutator: drive requests and raw halls in,
// gate drives, commutation state and speed measurement out.
interface bldc_commutator_if #(
  parameter int unsigned PWM_BITS = 10
);
  logic                enable;
  logic                direction;
  logic [2:0]          hall;
  logic [PWM_BITS-1:0] duty;
  logic [2:0]          hin;
  logic [2:0]          lin_n;
  logic [2:0]          state;
  logic [1:0]          mode;
  logic                hall_fault;
  logic [15:0]         edge_count;
  logic                edge_valid;

  modport master (output enable, direction, hall, duty,
                  input  hin, lin_n, state, mode, hall_fault, edge_count, edge_valid);
  modport slave  (input  enable, direction, hall, duty,
                  output hin, lin_n, state, mode, hall_fault, edge_count, edge_valid);
endinterface

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: forced open-loop start, hall-driven run, low-side PWM chop.
// Optional BLDC_DEADTIME_EN inserts DEADTIME all-off cycles at every state change.
module bldc_commutator #(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned PWM_BITS      = 10,
  parameter int unsigned FORCED_PERIOD = 2_500_000,
  parameter int unsigned SPEED_WINDOW  = 5_000_000,
  parameter int unsigned DEADTIME      = 50
) (
  input  logic             clk,
  input  logic             rst,
  bldc_commutator_if.slave bus
);
  localparam int unsigned STEP_W = (FORCED_PERIOD > 1) ? $clog2(FORCED_PERIOD) : 1;
  localparam int unsigned WIN_W  = (SPEED_WINDOW > 1) ? $clog2(SPEED_WINDOW) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FORCED_PERIOD - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SPEED_WINDOW - 1);

  if (FORCED_PERIOD == 0 || SPEED_WINDOW == 0 || PWM_BITS == 0 ||
      CLK_FREQ_HZ == 0 || DEADTIME > 32'h0000_FFFF) begin : g_bad_params
    $error("bldc_commutator: invalid parameter set");
  end

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_FORCED = 2'd1,
    MODE_HALL   = 2'd2,
    MODE_FAULT  = 2'd3
  } mode_t;

  mode_t               mode_q, mode_nxt;
  logic [2:0]          state_q, state_nxt;
  logic [STEP_W-1:0]   step_q, step_nxt;
  logic [2:0]          h_meta, hs, hs_d, prime;
  logic                bad_prev;
  logic [WIN_W-1:0]    win_q;
  logic [15:0]         edge_acc, edge_count_q;
  logic                edge_valid_q, hall_fault_q;
  logic [PWM_BITS-1:0] pwm_cnt, duty_lat;
  logic [2:0]          hin_q, lin_q, hin_c, lin_c;
  logic [3:0]          lookup_c;
  logic                hs_bad_c, fault_c, hall_edge_c, win_end_c, pwm_on_c, drive_c, gap_c;

  // {valid, state} for a synchronised hall code in the requested direction
  function automatic logic [3:0] hall_map(input logic [2:0] h, input logic cw);
    logic [3:0] r;
    r = 4'b0000;
    case (h)
      3'd1:    r = {1'b1, cw ? 3'd4 : 3'd1};
      3'd2:    r = {1'b1, cw ? 3'd0 : 3'd3};
      3'd3:    r = {1'b1, cw ? 3'd5 : 3'd2};
      3'd4:    r = {1'b1, cw ? 3'd2 : 3'd5};
      3'd5:    r = {1'b1, cw ? 3'd3 : 3'd0};
      3'd6:    r = {1'b1, cw ? 3'd1 : 3'd4};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // prime tracks which sync stages hold real samples so reset zeros never count as edges or faults
  assign hs_bad_c    = prime[1] && ((hs == 3'b000) || (hs == 3'b111));
  assign fault_c     = hs_bad_c && bad_prev;
  assign hall_edge_c = prime[2] && (hs != hs_d);
  assign win_end_c   = (win_q == WIN_LAST);
  assign lookup_c    = hall_map(hs, bus.direction);
  assign pwm_on_c    = (pwm_cnt < duty_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_meta   <= '0;
      hs       <= '0;
      hs_d     <= '0;
      prime    <= '0;
      bad_prev <= 1'b0;
    end else begin
      h_meta   <= bus.hall;
      hs       <= h_meta;
      hs_d     <= hs;
      prime    <= {prime[1:0], 1'b1};
      bad_prev <= hs_bad_c;
    end
  end

  // Speed window runs in every mode; an edge on the closing cycle opens the next window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q        <= '0;
      edge_acc     <= '0;
      edge_count_q <= '0;
      edge_valid_q <= 1'b0;
    end else begin
      edge_valid_q <= win_end_c;
      if (win_end_c) begin
        win_q        <= '0;
        edge_count_q <= edge_acc;
        edge_acc     <= 16'(hall_edge_c);
      end else begin
        win_q <= win_q + 1'b1;
        if (hall_edge_c && (edge_acc != 16'hFFFF)) edge_acc <= edge_acc + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt  <= '0;
      duty_lat <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) duty_lat <= bus.duty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q       <= MODE_IDLE;
      state_q      <= '0;
      step_q       <= '0;
      hall_fault_q <= 1'b0;
    end else begin
      mode_q       <= mode_nxt;
      state_q      <= state_nxt;
      step_q       <= step_nxt;
      hall_fault_q <= (mode_nxt == MODE_FAULT);
    end
  end

  always_comb begin
    mode_nxt  = mode_q;
    state_nxt = state_q;
    step_nxt  = '0;
    case (mode_q)
      MODE_IDLE: if (bus.enable) mode_nxt = MODE_FORCED;
      MODE_FORCED: begin
        if (step_q == STEP_LAST) begin
          if (bus.direction) state_nxt = (state_q == 3'd5) ? 3'd0 : state_q + 3'd1;
          else               state_nxt = (state_q == 3'd0) ? 3'd5 : state_q - 3'd1;
        end else begin
          step_nxt = step_q + 1'b1;
        end
        if (win_end_c && (edge_acc >= 16'd2)) mode_nxt = MODE_HALL;
      end
      MODE_HALL: begin
        if (lookup_c[3]) state_nxt = lookup_c[2:0];
        if (win_end_c && (edge_acc == 16'd0)) mode_nxt = MODE_FORCED;
      end
      default: mode_nxt = MODE_FAULT;
    endcase
    if (((mode_q == MODE_FORCED) || (mode_q == MODE_HALL)) && fault_c) mode_nxt = MODE_FAULT;
    if (!bus.enable) mode_nxt = MODE_IDLE;
  end

`ifdef BLDC_DEADTIME_EN
  localparam int unsigned DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  logic [2:0]      state_d;
  logic [DT_W-1:0] dt_q;
  logic            state_chg_c;

  // A change during the gap reloads the counter so the newest state waits the full time
  assign state_chg_c = (state_q != state_d);
  assign gap_c       = (DEADTIME != 0) && (state_chg_c || (dt_q != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_d <= '0;
      dt_q    <= '0;
    end else begin
      state_d <= state_q;
      if (state_chg_c)       dt_q <= DT_W'(DEADTIME - 1);
      else if (dt_q != '0)   dt_q <= dt_q - 1'b1;
    end
  end
`else
  assign gap_c = 1'b0;
`endif

  assign drive_c = ((mode_q == MODE_FORCED) || (mode_q == MODE_HALL)) && !gap_c;

  // High side held on; only the active low side follows the PWM
  always_comb begin
    hin_c = 3'b000;
    lin_c = 3'b111;
    if (drive_c) begin
      case (state_q)
        3'd0:    begin hin_c = 3'b001; lin_c[1] = ~pwm_on_c; end
        3'd1:    begin hin_c = 3'b001; lin_c[2] = ~pwm_on_c; end
        3'd2:    begin hin_c = 3'b010; lin_c[2] = ~pwm_on_c; end
        3'd3:    begin hin_c = 3'b010; lin_c[0] = ~pwm_on_c; end
        3'd4:    begin hin_c = 3'b100; lin_c[0] = ~pwm_on_c; end
        3'd5:    begin hin_c = 3'b100; lin_c[1] = ~pwm_on_c; end
        default: begin hin_c = 3'b000; lin_c = 3'b111; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hin_q <= 3'b000;
      lin_q <= 3'b111;
    end else begin
      hin_q <= hin_c;
      lin_q <= lin_c;
    end
  end

  assign bus.hin        = hin_q;
  assign bus.lin_n      = lin_q;
  assign bus.state      = state_q;
  assign bus.mode       = mode_q;
  assign bus.hall_fault = hall_fault_q;
  assign bus.edge_count = edge_count_q;
  assign bus.edge_valid = edge_valid_q;
endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator: forced start, hall run, PWM duty, fault, reset.
module tb_bldc_commutator;
  localparam int unsigned PWM_BITS = 4;
`ifdef BLDC_DEADTIME_EN
  localparam int unsigned DTL = 4;
`else
  localparam int unsigned DTL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [2:0]  seq [6] = '{3'd2, 3'd6, 3'd4, 3'd5, 3'd1, 3'd3};

  bldc_commutator_if #(.PWM_BITS(PWM_BITS)) bus ();

  bldc_commutator #(
    .CLK_FREQ_HZ(50_000_000), .PWM_BITS(PWM_BITS), .FORCED_PERIOD(100),
    .SPEED_WINDOW(1000), .DEADTIME(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (!rst) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Park on the falling edge after rising edge n (counted from reset release)
  task automatic at_cyc(input int unsigned n);
    int unsigned guard;
    guard = 0;
    while (cyc < n) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        miscompares++;
        $display("FAIL wait_cycle: observed cycle %0d required %0d", cyc, n);
        $fatal(1, "wait bound expired");
      end
    end
  endtask

  initial begin
    int lows;
    int viol;
    bus.enable    = 1'b0;
    bus.direction = 1'b1;
    bus.hall      = 3'b101;
    bus.duty      = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_mode",       16'(bus.mode),       16'd0);
    check("rst_state",      16'(bus.state),      16'd0);
    check("rst_hin",        16'(bus.hin),        16'h0);
    check("rst_lin_n",      16'(bus.lin_n),      16'h7);
    check("rst_hall_fault", 16'(bus.hall_fault), 16'd0);
    check("rst_edge_count", bus.edge_count,      16'd0);
    check("rst_edge_valid", 16'(bus.edge_valid), 16'd0);

    rst        = 1'b0;
    bus.enable = 1'b1;
    at_cyc(1);   check("forced_entry", 16'(bus.mode), 16'd1);
                 check("forced_state0", 16'(bus.state), 16'd0);
    at_cyc(100); check("forced_hold0", 16'(bus.state), 16'd0);
    at_cyc(101); check("forced_step1", 16'(bus.state), 16'd1);
                 check("s0_hin", 16'(bus.hin), 16'h1);
                 check("s0_lin_n", 16'(bus.lin_n), 16'h5);
    at_cyc(102);
`ifdef BLDC_DEADTIME_EN
    check("dt_hin_off", 16'(bus.hin), 16'h0);
    check("dt_lin_off", 16'(bus.lin_n), 16'h7);
    at_cyc(105); check("dt_hin_last_off", 16'(bus.hin), 16'h0);
    at_cyc(106); check("dt_hin_s1", 16'(bus.hin), 16'h1);
                 check("dt_lin_s1", 16'(bus.lin_n), 16'h3);
`else
    check("nodt_hin_s1", 16'(bus.hin), 16'h1);
    check("nodt_lin_s1", 16'(bus.lin_n), 16'h3);
`endif
    at_cyc(501);  check("forced_step5", 16'(bus.state), 16'd5);
    at_cyc(601);  check("forced_wrap0", 16'(bus.state), 16'd0);
    at_cyc(999);  check("win1_not_yet", 16'(bus.edge_valid), 16'd0);
    at_cyc(1000); check("win1_valid", 16'(bus.edge_valid), 16'd1);
                  check("win1_count", bus.edge_count, 16'd0);
                  check("win1_mode", 16'(bus.mode), 16'd1);

    for (int j = 0; j < 20; j++) begin
      at_cyc(32'(1000 + 50 * j));
      bus.hall = seq[j % 6];
    end
    at_cyc(1001); check("win1_pulse_end", 16'(bus.edge_valid), 16'd0);

    at_cyc(2000); check("win2_count", bus.edge_count, 16'd20);
                  check("win2_mode_hall", 16'(bus.mode), 16'd2);
                  check("win2_state", 16'(bus.state), 16'd1);
    bus.hall = 3'd4;
    at_cyc(2002); check("hall_lat_old", 16'(bus.state), 16'd1);
    at_cyc(2003); check("hall_lat_new", 16'(bus.state), 16'd2);
                  check("hall_hin_old", 16'(bus.hin), 16'h1);
    bus.duty = 4'd4;
    at_cyc(2004 + DTL); check("hall_hin_new", 16'(bus.hin), 16'h2);
    at_cyc(2017); check("duty4_on", 16'(bus.lin_n), 16'h3);
    lows = 0;
    viol = 0;
    for (int k = 2021; k < 2037; k++) begin
      at_cyc(32'(k));
      if (bus.lin_n[2] == 1'b0) lows++;
      if (bus.lin_n[1:0] != 2'b11 || bus.hin != 3'b010) viol++;
    end
    check("duty4_lows", 16'(lows), 16'd4);
    check("duty4_others", 16'(viol), 16'd0);
    bus.duty = 4'd0;
    viol = 0;
    for (int k = 2049; k < 2065; k++) begin
      at_cyc(32'(k));
      if (bus.lin_n != 3'b111 || bus.hin != 3'b010) viol++;
    end
    check("duty0_gates", 16'(viol), 16'd0);

    at_cyc(2070); check("dir_cw", 16'(bus.state), 16'd2);
    bus.direction = 1'b0;
    at_cyc(2071); check("dir_ccw", 16'(bus.state), 16'd5);
    bus.direction = 1'b1;
    at_cyc(2072); check("dir_back_cw", 16'(bus.state), 16'd2);

    at_cyc(2100); bus.hall = 3'b000;
    at_cyc(2103); check("fault_not_yet", 16'(bus.mode), 16'd2);
    at_cyc(2104); check("fault_mode", 16'(bus.mode), 16'd3);
                  check("fault_flag", 16'(bus.hall_fault), 16'd1);
    at_cyc(2105); check("fault_hin", 16'(bus.hin), 16'h0);
                  check("fault_lin_n", 16'(bus.lin_n), 16'h7);
    at_cyc(2110); bus.hall = 3'd4;
    at_cyc(2120); check("fault_sticky", 16'(bus.mode), 16'd3);
    bus.enable = 1'b0;
    at_cyc(2121); check("disable_idle", 16'(bus.mode), 16'd0);
                  check("disable_flag", 16'(bus.hall_fault), 16'd0);
    bus.enable = 1'b1;
    at_cyc(2122); check("reenable_forced", 16'(bus.mode), 16'd1);

    at_cyc(3000); check("win3_mode_hall", 16'(bus.mode), 16'd2);
                  check("win3_count", bus.edge_count, 16'd3);
                  check("win3_state", 16'(bus.state), 16'd4);
    bus.duty = 4'hF;
    at_cyc(3001);       check("rehall_state", 16'(bus.state), 16'd2);
    at_cyc(3006);       check("rehall_hin", 16'(bus.hin), 16'h2);
    at_cyc(3023);       check("dutymax_on", 16'(bus.lin_n), 16'h3);
    at_cyc(3024);       check("dutymax_gap", 16'(bus.lin_n), 16'h7);
    at_cyc(3025);       check("dutymax_on2", 16'(bus.lin_n), 16'h3);
                        check("pre_rst_hin", 16'(bus.hin), 16'h2);

    #2 rst = 1'b1;
    #1;
    check("async_hin", 16'(bus.hin), 16'h0);
    check("async_lin_n", 16'(bus.lin_n), 16'h7);
    check("async_mode", 16'(bus.mode), 16'd0);
    check("async_state", 16'(bus.state), 16'd0);
    check("async_edge_count", bus.edge_count, 16'd0);
    check("async_edge_valid", 16'(bus.edge_valid), 16'd0);
    check("async_hall_fault", 16'(bus.hall_fault), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bldc_commutator.md
BLDC_COMMUTATOR -- requirements
Module: bldc_commutator

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, input clock frequency (informational, for derived defaults).
REQ-002 SHALL have parameter PWM_BITS, default 10, duty/PWM counter width.
REQ-003 SHALL have parameter FORCED_PERIOD, default 2_500_000, clk cycles per forced-commutation step.
REQ-004 SHALL have parameter SPEED_WINDOW, default 5_000_000, clk cycles per speed-measurement window.
REQ-005 SHALL have parameter DEADTIME, default 50, clk cycles of all-off at each commutation (see REQ-027).
REQ-006 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports: enable  in  1  drive enable; direction  in  1  1=CW, 0=CCW; hall  in  3  raw hall sensors (asynchronous); duty  in  PWM_BITS  low-side on-time.
REQ-009 SHALL have ports: hin  out  3  upper-arm gates [R,S,T]=[0,1,2], 1=on; lin_n  out  3  lower-arm gates, 0=on; state  out  3  commutation state 0..5.
REQ-010 SHALL have ports: mode  out  2  0=IDLE,1=FORCED,2=HALL,3=FAULT; hall_fault  out  1  high while mode=FAULT; edge_count  out  16  hall edges in last window; edge_valid  out  1  one-cycle pulse when edge_count updates.

Function
REQ-011 SHALL synchronise hall through two flops; all hall logic uses the synchronised value hs.
REQ-012 SHALL map hs to state, CW: 1->4, 2->0, 3->5, 4->2, 5->3, 6->1; CCW: 1->1, 2->3, 3->2, 4->5, 5->0, 6->4; table chosen by current direction each cycle.
REQ-013 SHALL drive per state (high phase / low phase): 0 R/S, 1 R/T, 2 S/T, 3 S/R, 4 T/R, 5 T/S; the third phase fully off (hin=0, lin_n=1).
REQ-014 SHALL run a free-running PWM_BITS counter; duty latched when counter wraps to 0; pwm_on = counter < latched duty; duty=0 -> never on, duty=all-ones -> off one cycle per period.
REQ-015 SHALL chop only the low side: active low phase lin_n=0 only while pwm_on; high side on continuously.
REQ-016 SHALL register hin/lin_n; hall input change at cycle N appears on outputs by cycle N+4 (2 sync, state reg, output reg), dead-time excluded.
REQ-017 SHALL implement FSM IDLE, FORCED, HALL, FAULT; in IDLE and FAULT hin=3'b000, lin_n=3'b111.
REQ-018 SHALL transition IDLE->FORCED when enable=1; any state->IDLE next cycle when enable=0 (highest priority).
REQ-019 In FORCED SHALL advance state every FORCED_PERIOD cycles: +1 mod 6 CW, -1 mod 6 CCW (0 wraps to 5); step counter cleared on FORCED entry.
REQ-020 SHALL transition FORCED->HALL at window end with window edge count >=2; HALL->FORCED at window end with count 0.
REQ-021 In HALL SHALL take state from REQ-012; a direction change takes effect the next cycle.
REQ-022 SHALL enter FAULT from FORCED or HALL when hs is 3'b000 or 3'b111 for 2 consecutive cycles; FAULT exits only via enable=0.
REQ-023 SHALL count hs changes per SPEED_WINDOW, saturating at 16'hFFFF; at window end load edge_count, pulse edge_valid, clear counter; edge coinciding with window end counts in the new window.
REQ-024 SHALL run the speed window continuously in all modes, including IDLE.

Reset
REQ-025 SHALL on rst: mode=IDLE, state=0, hin=3'b000, lin_n=3'b111, hall_fault=0, edge_count=0, edge_valid=0, all counters and sync flops 0.
REQ-026 SHALL, on rst asserted mid-operation, force gate outputs off asynchronously in the same cycle.

Configuration
REQ-027 With macro BLDC_DEADTIME_EN defined, every state change SHALL hold all gates off (hin=0, lin_n=3'b111) for DEADTIME cycles before the new pattern; a further change during dead-time restarts it with the newest state.
REQ-028 Without BLDC_DEADTIME_EN, the new pattern SHALL be applied on the cycle after the state change; DEADTIME ignored.

Verification (bench parameters: PWM_BITS=4, FORCED_PERIOD=100, SPEED_WINDOW=1000, DEADTIME=4)
REQ-029 Reset then enable=1, direction=1, hall=0b101 static -> mode=FORCED, state 0,1,2.. each 100 cycles, wraps 5->0; edge_count=0 at each edge_valid.
REQ-030 hall stepping CW sequence 2,6,4,5,1,3 every 50 cycles -> at first window end edge_count=20, mode=HALL; state follows 0,1,2,3,4,5 with 4-cycle latency.
REQ-031 In HALL, duty=4 -> active lin_n low 4 of 16 cycles; duty=0 -> lin_n=3'b111 throughout, hin unchanged.
REQ-032 hall=0b000 for 2 cycles in HALL -> mode=FAULT, hall_fault=1, gates off; hall restored -> stays FAULT until enable=0, then IDLE.
REQ-033 With BLDC_DEADTIME_EN, state 0->1 -> 4 cycles all-off then R high/T low; without macro, no gap.
REQ-034 rst asserted mid-HALL -> gates off same cycle, all outputs at reset values.
